// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV        = 50000,
  parameter int unsigned DWELL      = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  output logic [3:0]              bcd_out,
  input  logic [6:0]              seg_in,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DW_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    tick;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [DW_W-1:0]         dwell, dwell_nxt;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic                    wrap;
  logic                    blank_digit;
  logic [DATA_W-1:0]       shadow;
  logic [DATA_W-1:0]       pending;
  logic                    pend_v;

  // Refresh prescaler: one tick every DIV clocks
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_W'(DIV - 1));

  // State, digit index and registered pin drivers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_BLANK;
      idx     <= '0;
      dwell   <= '0;
      seg_out <= 7'h7F;
      an_out  <= '1;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      dwell   <= dwell_nxt;
      seg_out <= seg_nxt;
      an_out  <= an_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dwell_nxt = dwell;
    seg_nxt   = seg_out;
    an_nxt    = an_out;
    wrap      = 1'b0;
    if (tick) begin
      case (state)
        ST_BLANK: begin
          state_nxt = ST_DRIVE;
          dwell_nxt = '0;
          seg_nxt   = blank_digit ? 7'h7F : seg_in;
          an_nxt    = ~(NUM_DIGITS'(1) << idx);
        end
        ST_DRIVE: begin
          if (dwell == DW_W'(DWELL - 1)) begin
            state_nxt = ST_BLANK;
            dwell_nxt = '0;
            seg_nxt   = 7'h7F;
            an_nxt    = '1;
            if (idx == IDX_W'(NUM_DIGITS - 1)) begin
              idx_nxt = '0;
              wrap    = 1'b1;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end else begin
            dwell_nxt = dwell + DW_W'(1);
          end
        end
        default: state_nxt = ST_BLANK;
      endcase
    end
  end

  assign frame_done = wrap;

  // Display value only changes at a frame boundary; a load on the wrap cycle bypasses pending
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow  <= '0;
      pending <= '0;
      pend_v  <= 1'b0;
    end else if (wrap && load) begin
      shadow  <= digits_in;
      pending <= digits_in;
      pend_v  <= 1'b0;
    end else if (wrap && pend_v) begin
      shadow  <= pending;
      pend_v  <= 1'b0;
    end else if (load) begin
      pending <= digits_in;
      pend_v  <= 1'b1;
    end
  end

  assign bcd_out = shadow[{idx, 2'b00} +: 4];

`ifdef SEG_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lz;
  logic                  all_zero;

  // lz[k]: nibble k and every higher nibble are zero
  always_comb begin
    all_zero = 1'b1;
    lz       = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero = all_zero && (shadow[4*k +: 4] == 4'h0);
      lz[k]    = all_zero;
    end
  end

  assign blank_digit = (idx != '0) && lz[idx];
`else
  assign blank_digit = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (NUM_DIGITS=4, DIV=4, DWELL=2).
// Define SEG_SCAN_LZB_EN for both DUT and bench to check leading-zero blanking.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_in;
  logic        load;
  logic [3:0]  bcd_out;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_done;

  int n_chk;
  int n_fail;
  int ecnt;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'h7F;
`ifdef SEG_SCAN_LZB_EN
  localparam logic [6:0] SZ = 7'h7F;
`else
  localparam logic [6:0] SZ = 7'b1000000;
`endif

  seg_scan_ctrl #(
    .NUM_DIGITS(4),
    .DIV       (4),
    .DWELL     (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_in (digits_in),
    .load      (load),
    .bcd_out   (bcd_out),
    .seg_in    (seg_in),
    .seg_out   (seg_out),
    .an_out    (an_out),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shared decoder, active-low gfedcba; A-F blank
  always_comb begin
    case (bcd_out)
      4'h0:    seg_in = 7'b1000000;
      4'h1:    seg_in = 7'b1111001;
      4'h2:    seg_in = 7'b0100100;
      4'h3:    seg_in = 7'b0110000;
      4'h4:    seg_in = 7'b0011001;
      4'h5:    seg_in = 7'b0010010;
      4'h6:    seg_in = 7'b0000010;
      4'h7:    seg_in = 7'b1111000;
      4'h8:    seg_in = 7'b0000000;
      4'h9:    seg_in = 7'b0010000;
      default: seg_in = 7'h7F;
    endcase
  end

  // Rising edges since the last reset edge
  always @(posedge clk) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    chk({tag, ".an"}, 16'(an_out), 16'(exp_an));
    chk({tag, ".seg"}, 16'(seg_out), 16'(exp_seg));
  endtask

  // Advance to the falling edge after rising edge n (counted from reset release)
  task automatic at_edge(input int n);
    int g;
    g = 0;
    while (ecnt < n && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (ecnt < n) chk("at_edge_timeout", 16'(ecnt), 16'(n));
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    load      = 1'b0;
    digits_in = 16'h0000;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_disp("reset", 4'hF, SB);
    chk("reset.fd", 16'(frame_done), 16'(1'b0));
    chk("reset.bcd", 16'(bcd_out), 16'(4'h0));
    rst_n = 1'b1;

    at_edge(3);
    chk_disp("pre_first_drive", 4'hF, SB);
    at_edge(4);
    chk_disp("first_drive", 4'hE, S0);

    // Load 1234 in frame 1; takes effect at the first wrap
    at_edge(10);
    load = 1'b1; digits_in = 16'h1234;
    at_edge(11);
    load = 1'b0; digits_in = 16'h0000;
    at_edge(30);
    chk_disp("f1_d2_old", 4'hB, S0);
    at_edge(46);
    chk("fd_before", 16'(frame_done), 16'(1'b0));
    at_edge(47);
    chk("fd_pulse", 16'(frame_done), 16'(1'b1));
    at_edge(48);
    chk("fd_after", 16'(frame_done), 16'(1'b0));
    chk_disp("wrap_blank", 4'hF, SB);
    chk("wrap_bcd", 16'(bcd_out), 16'(4'h4));

    // Frame 2 shows 1234
    at_edge(54);  chk_disp("f2_d0", 4'hE, S4);
    at_edge(62);  chk_disp("f2_blank", 4'hF, SB);
    at_edge(66);  chk_disp("f2_d1", 4'hD, S3);
    at_edge(78);  chk_disp("f2_d2", 4'hB, S2);
    at_edge(90);  chk_disp("f2_d3", 4'h7, S1);

    // Two loads mid-frame 3: frame 3 unchanged, frame 4 shows the last one
    at_edge(100);
    load = 1'b1; digits_in = 16'h5678;
    at_edge(101);
    load = 1'b0;
    at_edge(110);
    load = 1'b1; digits_in = 16'h9999;
    at_edge(111);
    load = 1'b0; digits_in = 16'h0000;
    at_edge(114); chk_disp("f3_d1", 4'hD, S3);
    at_edge(138); chk_disp("f3_d3", 4'h7, S1);
    at_edge(150); chk_disp("f4_d0", 4'hE, S9);
    at_edge(174); chk_disp("f4_d2", 4'hB, S9);
    at_edge(186); chk_disp("f4_d3", 4'h7, S9);

    // Load on the frame_done cycle bypasses straight into the display
    at_edge(191);
    chk("fd_f4", 16'(frame_done), 16'(1'b1));
    load = 1'b1; digits_in = 16'h0042;
    at_edge(192);
    load = 1'b0; digits_in = 16'h0000;
    chk("bypass_bcd", 16'(bcd_out), 16'(4'h2));
    at_edge(198); chk_disp("f5_d0", 4'hE, S2);
    at_edge(200);
    load = 1'b1; digits_in = 16'h00A0;
    at_edge(201);
    load = 1'b0; digits_in = 16'h0000;
    at_edge(210); chk_disp("f5_d1", 4'hD, S4);
    at_edge(222); chk_disp("f5_d2", 4'hB, SZ);

    // Invalid nibble on digit 1: blank segments, anode still driven
    at_edge(246); chk_disp("f6_d0", 4'hE, S0);
    at_edge(250);
    load = 1'b1; digits_in = 16'h0070;
    at_edge(251);
    load = 1'b0; digits_in = 16'h0000;
    at_edge(258);
    chk_disp("f6_d1_inv", 4'hD, SB);
    chk("f6_d1_bcd", 16'(bcd_out), 16'(4'hA));
    at_edge(270); chk_disp("f6_d2", 4'hB, SZ);
    at_edge(282); chk_disp("f6_d3", 4'h7, SZ);

    // 0070: leading zeros blank only when the option is built in
    at_edge(294); chk_disp("f7_d0", 4'hE, S0);
    at_edge(306); chk_disp("f7_d1", 4'hD, S7);
    at_edge(318); chk_disp("f7_d2", 4'hB, SZ);
    at_edge(330); chk_disp("f7_d3", 4'h7, SZ);

    // Pending load then reset during digit 2 DRIVE clears everything
    at_edge(340);
    load = 1'b1; digits_in = 16'h8888;
    at_edge(341);
    load = 1'b0; digits_in = 16'h0000;
    at_edge(366);
    chk_disp("f8_d2", 4'hB, SZ);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_disp("midreset", 4'hF, SB);
    chk("midreset.fd", 16'(frame_done), 16'(1'b0));
    chk("midreset.bcd", 16'(bcd_out), 16'(4'h0));
    at_edge(4);   chk_disp("post_rst_d0", 4'hE, S0);
    at_edge(54);  chk_disp("post_rst_f2_d0", 4'hE, S0);
    at_edge(66);  chk_disp("post_rst_f2_d1", 4'hD, SZ);
    at_edge(78);  chk_disp("post_rst_f2_d2", 4'hB, SZ);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
